// File: rtl/fetch_unit.sv
// Instruction fetch stage with F/D pipeline register.
// Holds the fetch PC and the D-stage instruction bundle. It detects fetch
// address errors (AdEL) and replaces the faulting instruction with a nop
// that carries exception code 4 into D.
//
// Update priority on each rising clock edge:
//   reset > Req > Stall > flush > normal advance.
// Stall freezes both the PC and the D registers. A flush raised during a
// stall is not latched; the next-PC logic must keep flush high until Stall
// drops for the redirect to take effect.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCnxt,
  input  logic        nxtBD,
  input  logic        flush,
  input  logic        Stall,
  input  logic        Req,
  input  logic [31:0] F_Instr,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_BD,
  output logic [4:0]  D_ExcCode
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFF;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  logic [31:0] pc_q;
  logic        adel;

  // Fetch address error: misaligned or outside instruction memory.
  always_comb begin
    adel = 1'b0;
    if ((pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI)) begin
      adel = 1'b1;
    end
  end

  // PC register and F/D pipeline register, updated in priority order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      D_PC      <= RESET_PC;
      D_Instr   <= 32'h0;
      D_BD      <= 1'b0;
      D_ExcCode <= 5'd0;
    end else if (Req) begin
      pc_q      <= EXC_PC;
      D_PC      <= EXC_PC;
      D_Instr   <= 32'h0;
      D_BD      <= 1'b0;
      D_ExcCode <= 5'd0;
    end else if (Stall) begin
      pc_q      <= pc_q;
      D_PC      <= D_PC;
      D_Instr   <= D_Instr;
      D_BD      <= D_BD;
      D_ExcCode <= D_ExcCode;
    end else if (flush) begin
      pc_q      <= PCnxt;
      D_PC      <= pc_q;
      D_Instr   <= 32'h0;
      D_BD      <= 1'b0;
      D_ExcCode <= 5'd0;
    end else begin
      pc_q      <= PCnxt;
      D_PC      <= pc_q;
      // The delay-slot flag is kept even on AdEL so that EPC = D_PC - 4.
      D_BD      <= nxtBD;
      if (adel) begin
        D_Instr   <= 32'h0;
        D_ExcCode <= EXC_ADEL;
      end else begin
        D_Instr   <= F_Instr;
        D_ExcCode <= 5'd0;
      end
    end
  end

  // The fetch address comes straight from the register, with no combinational input path.
  assign F_PC = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit.
// Inputs change 1 ns after a rising edge. Outputs are checked at that
// point, which is well clear of the next active edge.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] PCnxt;
  logic        nxtBD;
  logic        flush;
  logic        Stall;
  logic        Req;
  logic [31:0] F_Instr;
  logic [31:0] F_PC;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic        D_BD;
  logic [4:0]  D_ExcCode;

  int checks;
  int fails;

  localparam logic [31:0] INSTR = 32'h2401_0001;

  fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .PCnxt     (PCnxt),
    .nxtBD     (nxtBD),
    .flush     (flush),
    .Stall     (Stall),
    .Req       (Req),
    .F_Instr   (F_Instr),
    .F_PC      (F_PC),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .D_BD      (D_BD),
    .D_ExcCode (D_ExcCode)
  );

  // Clock generation: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 ns past the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Check every D-stage output and the fetch PC together.
  task automatic chk_all(input string tag, input logic [31:0] fpc, input logic [31:0] dpc,
                         input logic [31:0] dinstr, input logic dbd, input logic [4:0] exc);
    chk({tag, ".F_PC"}, F_PC, fpc);
    chk({tag, ".D_PC"}, D_PC, dpc);
    chk({tag, ".D_Instr"}, D_Instr, dinstr);
    chk({tag, ".D_BD"}, {31'b0, D_BD}, {31'b0, dbd});
    chk({tag, ".D_ExcCode"}, {27'b0, D_ExcCode}, {27'b0, exc});
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    reset   = 1'b1;
    PCnxt   = 32'h0000_5000;
    nxtBD   = 1'b1;
    flush   = 1'b1;
    Stall   = 1'b1;
    Req     = 1'b1;
    F_Instr = INSTR;

    // Reset dominates Req, Stall and flush.
    step;
    step;
    chk_all("reset", 32'h3000, 32'h3000, 32'h0, 1'b0, 5'd0);

    reset = 1'b0;
    Req   = 1'b0;
    Stall = 1'b0;
    flush = 1'b0;
    nxtBD = 1'b0;
    PCnxt = 32'h3004;
    step;
    chk_all("adv1", 32'h3004, 32'h3000, INSTR, 1'b0, 5'd0);
    PCnxt = 32'h3008;
    step;
    chk_all("adv2", 32'h3008, 32'h3004, INSTR, 1'b0, 5'd0);

    // Stall for 2 cycles. A changed F_Instr and a concurrent flush must both be ignored.
    Stall   = 1'b1;
    flush   = 1'b1;
    PCnxt   = 32'h3010;
    F_Instr = 32'hAAAA_AAAA;
    step;
    chk_all("stall1", 32'h3008, 32'h3004, INSTR, 1'b0, 5'd0);
    step;
    chk_all("stall2", 32'h3008, 32'h3004, INSTR, 1'b0, 5'd0);

    // Release the stall. The instruction at 0x3008 enters D as a delay-slot instruction.
    Stall   = 1'b0;
    flush   = 1'b0;
    nxtBD   = 1'b1;
    PCnxt   = 32'h300C;
    F_Instr = INSTR;
    step;
    chk_all("bd1", 32'h300C, 32'h3008, INSTR, 1'b1, 5'd0);
    nxtBD = 1'b0;
    PCnxt = 32'h3010;
    step;
    chk_all("bd0", 32'h3010, 32'h300C, INSTR, 1'b0, 5'd0);

    // Misaligned fetch address.
    PCnxt = 32'h3002;
    step;
    chk_all("mis_f", 32'h3002, 32'h3010, INSTR, 1'b0, 5'd0);
    nxtBD = 1'b1;
    PCnxt = 32'h7000;
    step;
    chk_all("mis_d", 32'h7000, 32'h3002, 32'h0, 1'b1, 5'd4);
    // The address just above the instruction memory upper bound.
    nxtBD = 1'b0;
    PCnxt = 32'h6FFC;
    step;
    chk_all("hi_out", 32'h6FFC, 32'h7000, 32'h0, 1'b0, 5'd4);
    // The last valid word, then the word just below the lower bound.
    PCnxt = 32'h2FFC;
    step;
    chk_all("hi_in", 32'h2FFC, 32'h6FFC, INSTR, 1'b0, 5'd0);
    PCnxt = 32'h3000;
    step;
    chk_all("lo_out", 32'h3000, 32'h2FFC, 32'h0, 1'b0, 5'd4);

    // Req wins over Stall and flush.
    Req   = 1'b1;
    Stall = 1'b1;
    flush = 1'b1;
    PCnxt = 32'h3020;
    step;
    chk_all("req", 32'h4180, 32'h4180, 32'h0, 1'b0, 5'd0);

    // Flush inserts a bubble, and nxtBD is ignored.
    Req   = 1'b0;
    Stall = 1'b0;
    nxtBD = 1'b1;
    step;
    chk_all("flush", 32'h3020, 32'h4180, 32'h0, 1'b0, 5'd0);

    // A flush raised during a stall takes effect only once the stall drops.
    nxtBD = 1'b0;
    Stall = 1'b1;
    PCnxt = 32'h3040;
    step;
    chk_all("fl_stall", 32'h3020, 32'h4180, 32'h0, 1'b0, 5'd0);
    Stall = 1'b0;
    step;
    chk_all("fl_late", 32'h3040, 32'h3020, 32'h0, 1'b0, 5'd0);

    // Reset is asserted asynchronously in the middle of a stall.
    flush = 1'b0;
    Stall = 1'b1;
    PCnxt = 32'h3044;
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst_async", 32'h3000, 32'h3000, 32'h0, 1'b0, 5'd0);
    step;
    chk_all("rst_hold", 32'h3000, 32'h3000, 32'h0, 1'b0, 5'd0);

    // Normal advance resumes on the first edge after reset is released.
    reset = 1'b0;
    Stall = 1'b0;
    PCnxt = 32'h3004;
    step;
    chk_all("rst_resume", 32'h3004, 32'h3000, INSTR, 1'b0, 5'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port PCnxt  input  32  next fetch address from next-PC logic.
REQ-004 SHALL have port nxtBD  input  1  next-PC logic reports a jump/branch in D; the instruction now being fetched is a delay slot.
REQ-005 SHALL have port flush  input  1  eret redirect from next-PC logic; PCnxt holds EPC.
REQ-006 SHALL have port Stall  input  1  hazard stall from hazard unit; freeze F and D.
REQ-007 SHALL have port Req  input  1  exception/interrupt entry request from CP0.
REQ-008 SHALL have port F_Instr  input  32  instruction read combinationally from instruction memory at F_PC.
REQ-009 SHALL have port F_PC  output  32  current fetch address; drives instruction memory and next-PC logic PCnow.
REQ-010 SHALL have port D_PC  output  32  registered PC of the instruction in D.
REQ-011 SHALL have port D_Instr  output  32  registered instruction in D.
REQ-012 SHALL have port D_BD  output  1  D instruction is a branch delay slot.
REQ-013 SHALL have port D_ExcCode  output  5  fetch exception code carried with the D instruction; 0 = none.

Function
REQ-014 SHALL update registers with priority: reset > Req > Stall > flush > normal advance.
REQ-015 SHALL on Req load F_PC = 0x00004180, D_PC = 0x00004180, D_Instr = 0, D_BD = 0, D_ExcCode = 0, regardless of Stall or flush.
REQ-016 SHALL on Stall (no Req) hold F_PC, D_PC, D_Instr, D_BD, D_ExcCode unchanged; flush asserted with Stall is ignored that cycle and acts when Stall drops.
REQ-017 SHALL on flush (no Req, no Stall) load F_PC = PCnxt and insert a bubble: D_Instr = 0, D_PC = F_PC, D_BD = 0, D_ExcCode = 0.
REQ-018 SHALL on normal advance load F_PC = PCnxt, D_PC = F_PC, D_BD = nxtBD, and D_Instr/D_ExcCode per REQ-019/020.
REQ-019 SHALL flag fetch AdEL when F_PC[1:0] != 0 or F_PC outside 0x00003000..0x00006FFF inclusive.
REQ-020 SHALL on normal advance with AdEL load D_ExcCode = 5'd4 and D_Instr = 0 (nop); otherwise D_ExcCode = 0, D_Instr = F_Instr.
REQ-021 SHALL keep D_BD from nxtBD even when AdEL is flagged, so CP0 computes EPC = D_PC - 4.
REQ-022 SHALL drive F_PC directly from the PC register with no combinational path from any input.
REQ-023 SHALL add one cycle of latency from F_PC to D outputs; no other buffering.
REQ-024 SHALL perform no arithmetic on PCnxt; all 32 bits loaded verbatim, including misaligned values.

Reset
REQ-025 SHALL on reset asynchronously set F_PC = 0x00003000, D_PC = 0x00003000, D_Instr = 0, D_BD = 0, D_ExcCode = 0.
REQ-026 SHALL hold reset values while reset is high, overriding Req, Stall and flush, including reset asserted mid-stall.
REQ-027 SHALL resume normal advance on the first rising edge after reset deasserts.

Verification
REQ-028 SHALL cover: reset, then PCnxt = F_PC+4 for 3 cycles, F_Instr = 0x24010001 -> F_PC 0x3000, 0x3004, 0x3008; D_PC lags by one cycle; D_Instr = 0x24010001.
REQ-029 SHALL cover: Stall high 2 cycles with PCnxt = 0x3010 -> F_PC, D_PC, D_Instr unchanged both cycles; advance on the cycle after Stall drops.
REQ-030 SHALL cover: nxtBD = 1 with F_PC = 0x3008 -> next cycle D_PC = 0x3008, D_BD = 1; D_BD returns to 0 on the next non-branch advance.
REQ-031 SHALL cover: PCnxt = 0x3002 advanced -> F_PC = 0x3002, next cycle D_ExcCode = 4, D_Instr = 0; and PCnxt = 0x7000 -> same AdEL result.
REQ-032 SHALL cover: Req with Stall and flush all high -> F_PC = 0x4180, D_PC = 0x4180, D_Instr = 0, D_BD = 0; then flush with PCnxt = 0x3020 -> F_PC = 0x3020, D_Instr = 0.
